rotl_iter: RTL and testbench

- Multi-cycle variable left rotator; the inverse of the fixed right-rotate helpers in the SHA-256 datapath.
- Accepts a word and a rotate amount over a valid/ready handshake, then rotates left by up to STEP bits per cycle.
- Presents the result over a valid/ready handshake.
- Used to undo right rotations in the schedule/compression debug path without a full barrel shifter.

---
 rtl/rot_pkg.sv | 14 +
 rtl/rotl_step.sv | 17 +
 rtl/rotl_iter.sv | 101 ++++++++++
 tb/tb_rotl_iter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared types for the iterative rotator: FSM state, reference width and amount type.
package rot_pkg;

    localparam int unsigned ROT_WIDTH = 32;

    typedef logic [$clog2(ROT_WIDTH)-1:0] rot_amt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } rotl_state_t;

endpackage

// File: rtl/rotl_step.sv
// Combinational left rotate of a WIDTH-bit word by 0..STEP bits.
module rotl_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    localparam int unsigned SW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SW-1:0]    amt,
    output logic [WIDTH-1:0] dout_c
);

    // Shifting the doubled word and keeping the upper half wraps MSBs into the LSBs.
    always_comb begin
        dout_c = WIDTH'(({din, din} << amt) >> WIDTH);
    end

endmodule

// File: rtl/rotl_iter.sv
// Multi-cycle variable left rotator with valid/ready request and result handshakes.
// Optional right-rotation request via in_dir when ROTL_RIGHT_EN is defined.
module rotl_iter
    import rot_pkg::*;
#(
    parameter int unsigned WIDTH = ROT_WIDTH,
    parameter int unsigned STEP  = 1,
    localparam int unsigned AW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
`ifdef ROTL_RIGHT_EN
    input  logic             in_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned SW = $clog2(STEP + 1);

    rotl_state_t      state;
    logic [WIDTH-1:0] data_reg;
    logic [AW-1:0]    rem;
    logic [AW-1:0]    load_amt;
    logic [SW-1:0]    step_amt;
    logic [WIDTH-1:0] step_data;

    // Right rotation by n is a left rotation by (WIDTH - n) mod WIDTH.
`ifdef ROTL_RIGHT_EN
    always_comb begin
        load_amt = in_dir ? AW'(WIDTH - 32'(in_amt)) : in_amt;
    end
`else
    always_comb begin
        load_amt = in_amt;
    end
`endif

    always_comb begin
        step_amt = (rem < AW'(STEP)) ? SW'(rem) : SW'(STEP);
    end

    rotl_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .din    (data_reg),
        .amt    (step_amt),
        .dout_c (step_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_reg  <= '0;
            rem       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_reg <= in_data;
                        rem      <= load_amt;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (rem != '0) begin
                        data_reg <= step_data;
                        rem      <= rem - AW'(step_amt);
                    end else begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign out_data = data_reg;

endmodule

// File: tb/tb_rotl_iter.sv
// Bench for rotl_iter: STEP=1 and STEP=4 instances against a cycle-level reference model.
module tb_rotl_iter;
    import rot_pkg::*;

    logic        clk;
    logic        rst;
    logic        iv   [2];
    logic        ir   [2];
    logic [31:0] id   [2];
    rot_amt_t    ia   [2];
    logic        idir [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [31:0] od   [2];

    int          n_tests;
    int          n_fail;
    int          cyc;
    logic        chk_en;

    logic        m_job [2];
    int          m_rdy [2];
    logic [31:0] m_exp [2];
    int          steps [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rotl_iter #(.WIDTH(32), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_amt(ia[0]),
`ifdef ROTL_RIGHT_EN
        .in_dir(idir[0]),
`endif
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0])
    );

    rotl_iter #(.WIDTH(32), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_amt(ia[1]),
`ifdef ROTL_RIGHT_EN
        .in_dir(idir[1]),
`endif
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1])
    );

    function automatic logic [31:0] m_rotl(input logic [31:0] d, input int a);
        int r;
        r = a % 32;
        if (r == 0) return d;
        return (d << r) | (d >> (32 - r));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a job becomes visible once its latency has elapsed after accept.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int amt;
            if (rst) begin
                m_job[i] = 1'b0;
            end else if (!m_job[i] && iv[i]) begin
                amt = int'(ia[i]);
                if (idir[i]) amt = (32 - amt) % 32;
                m_job[i] = 1'b1;
                m_rdy[i] = cyc + (amt + steps[i] - 1) / steps[i] + 1;
                m_exp[i] = m_rotl(id[i], amt);
            end else if (m_job[i] && cyc > m_rdy[i] && ordy[i]) begin
                m_job[i] = 1'b0;
            end
        end
        cyc++;
    end

    // Every-cycle comparison of handshake outputs and result data.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic vnow;
                vnow = m_job[i] && (cyc > m_rdy[i]);
                check($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(!m_job[i]));
                check($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(vnow));
                if (vnow) check($sformatf("out_data[%0d]", i), od[i], m_exp[i]);
            end
        end
    end

    task automatic run_job(input int i, input logic [31:0] d, input int a, input logic dir,
                           input logic [31:0] exp_d, input int exp_lat, input string name);
        int n;
        @(negedge clk);
        iv[i] = 1'b1; id[i] = d; ia[i] = rot_amt_t'(a); idir[i] = dir;
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        n = 0;
        while (!ov[i] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(exp_lat));
        check({name, " data"}, od[i], exp_d);
        @(negedge clk);
        ordy[i] = 1'b1;
        @(posedge clk);
        #1;
        ordy[i] = 1'b0;
        idir[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        n_tests = 0; n_fail = 0; cyc = 0; chk_en = 1'b0;
        steps[0] = 1; steps[1] = 4;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; id[i] = '0; ia[i] = '0; idir[i] = 1'b0; ordy[i] = 1'b0;
            m_job[i] = 1'b0; m_rdy[i] = 0; m_exp[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset out_data[0]", od[0], 32'h0);
        check("reset out_data[1]", od[1], 32'h0);
        chk_en = 1'b1;

        run_job(0, 32'h0000_0001, 17, 1'b0, 32'h0002_0000, 18, "s1 amt17");
        run_job(0, 32'h2B3C_091A, 17, 1'b0, 32'h1234_5678, 18, "s1 undo rotr17");
        run_job(0, 32'h0000_0003, 1,  1'b0, 32'h0000_0006, 2,  "s1 amt1");
        run_job(0, 32'h8000_0001, 31, 1'b0, 32'hC000_0000, 32, "s1 amt31");
        run_job(1, 32'h8000_0001, 5,  1'b0, 32'h0000_0030, 3,  "s4 amt5");
        run_job(1, 32'h1234_5678, 8,  1'b0, 32'h3456_7812, 3,  "s4 amt8");
        run_job(1, 32'h8000_0000, 31, 1'b0, 32'h4000_0000, 9,  "s4 amt31");
        run_job(1, 32'hCAFE_F00D, 0,  1'b0, 32'hCAFE_F00D, 1,  "s4 amt0");
`ifdef ROTL_RIGHT_EN
        run_job(0, 32'h1234_5678, 17, 1'b1, 32'h2B3C_091A, 16, "s1 right17");
        run_job(1, 32'h1234_5678, 0,  1'b1, 32'h1234_5678, 1,  "s4 right0");
`endif

        // Result hold with out_ready low, while a new request must be ignored.
        @(negedge clk);
        iv[0] = 1'b1; id[0] = 32'hDEAD_BEEF; ia[0] = '0;
        @(posedge clk);
        #1;
        id[0] = 32'h1111_1111; ia[0] = rot_amt_t'(3);
        @(posedge clk);
        #1;
        check("amt0 valid next cycle", 32'(ov[0]), 32'd1);
        held = od[0];
        check("amt0 data", held, 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("hold out_valid", 32'(ov[0]), 32'd1);
            check("hold out_data", od[0], 32'hDEAD_BEEF);
            check("hold in_ready", 32'(ir[0]), 32'd0);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        check("release in_ready", 32'(ir[0]), 32'd1);
        check("release out_valid", 32'(ov[0]), 32'd0);

        // Reset in the middle of a long rotation discards the job.
        @(negedge clk);
        iv[0] = 1'b1; id[0] = 32'h0F0F_0F0F; ia[0] = rot_amt_t'(20);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid-reset out_valid", 32'(ov[0]), 32'd0);
        check("mid-reset out_data", od[0], 32'h0);
        check("mid-reset in_ready", 32'(ir[0]), 32'd1);
        ordy[0] = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        run_job(0, 32'h0000_8000, 16, 1'b0, 32'h8000_0000, 17, "s1 after reset");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
